// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: main-decoder FSM plus ALU decoder.
// The FSM sequences one instruction at a time through a shared memory port.
// It waits on mem_ready in every memory state, so memory latency can vary.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 3,
  parameter bit EN_BNE     = 1'b1,
  parameter bit EN_ADDI    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  iord,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            pc_src,
  output logic                  pc_en,
  output logic                  instr_done,
  output logic                  illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, next_state;

  // Resize a 3-bit ALU operation code to the configured port width.
  function automatic logic [ALU_CTRL_W-1:0] alu_code(input logic [2:0] code);
    return ALU_CTRL_W'(code);
  endfunction

  // R-type funct fields the datapath ALU can execute.
  function automatic logic funct_legal(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  // ALU decoder for R-type instructions; unsupported functs never reach EXEC.
  function automatic logic [2:0] funct_op(input logic [5:0] f);
    logic [2:0] code;
    code = ALU_ADD;
    case (f)
      6'b100010: code = ALU_SUB;
      6'b100100: code = ALU_AND;
      6'b100101: code = ALU_OR;
      6'b101010: code = ALU_SLT;
      default:   code = ALU_ADD;
    endcase
    return code;
  endfunction

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  // Next-state and output decode; every output starts from its idle value.
  always_comb begin
    next_state  = state;
    mem_req     = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = alu_code(ALU_ADD);
    pc_src      = 2'b00;
    pc_en       = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    if (!reset_n) begin
      // Present the FETCH selects with every strobe held off.
      next_state = S_FETCH;
      alu_src_b  = 2'b01;
    end else begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_en      = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          // Branch target is computed speculatively into ALUOut here.
          alu_src_b = 2'b11;
          case (op)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_RTYPE: begin
              if (funct_legal(funct)) begin
                next_state = S_EXEC;
              end else begin
                next_state = S_FETCH;
                illegal_op = 1'b1;
              end
            end
            OP_BEQ: next_state = S_BRANCH;
            OP_BNE: begin
              if (EN_BNE) begin
                next_state = S_BRANCH;
              end else begin
                next_state = S_FETCH;
                illegal_op = 1'b1;
              end
            end
            OP_ADDI: begin
              if (EN_ADDI) begin
                next_state = S_ADDIEX;
              end else begin
                next_state = S_FETCH;
                illegal_op = 1'b1;
              end
            end
            OP_J: next_state = S_JUMP;
            default: begin
              next_state = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            next_state = S_FETCH;
          end
        end
        S_EXEC: begin
          alu_src_a   = 1'b1;
          alu_control = alu_code(funct_op(funct));
          next_state  = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = alu_code(ALU_SUB);
          pc_src      = 2'b01;
          pc_en       = (op == OP_BNE) ? ~alu_zero : alu_zero;
          instr_done  = 1'b1;
          next_state  = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          next_state = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          pc_src     = 2'b10;
          pc_en      = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule
